// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 128-point radix-2 SDF FFT input controller.
//   FFT_N   : log2 of the transform size (width of cnt_1 and out_idx)
//   FFT_PTS : transform size in points
//   FFT_LAT : pipeline advances from sample accept to that sample's output
//             slot (127-deep delay lines plus 7 stage registers)
//   ctrl_state_t : frame controller states
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N   = 7;
  localparam int FFT_PTS = 128;
  localparam int FFT_LAT = 134;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/fft_tag_delay.sv
// ---------------------------------------------------------------------------
// fft_tag_delay
// LAT-deep 1-bit shift register that travels alongside the FFT datapath and
// marks which pipeline slots hold real samples.
//   clk     : system clock
//   rst     : asynchronous active-high reset, clears every slot
//   en      : shift enable (pipeline advance)
//   din     : bit entering the head slot (1 = real sample, 0 = bubble)
//   tail    : bit in the last slot, i.e. the slot at the pipeline output
//   any_set : at least one slot holds a real sample
// The occupancy flag comes from a running population count updated with the
// bits entering and leaving, so it never needs a LAT-wide OR tree.
// ---------------------------------------------------------------------------
module fft_tag_delay
  import fft_pkg::*;
#(
  parameter int LAT = FFT_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic tail,
  output logic any_set
);

  localparam int CW = $clog2(LAT + 1);

  logic [LAT-1:0] tag_reg;
  logic [CW-1:0]  pop_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg[0] <= 1'b0;
    end else if (en) begin
      tag_reg[0] <= din;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_tag
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_reg[gi] <= 1'b0;
        end else if (en) begin
          tag_reg[gi] <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  // Count of set slots: +1 for a real bit entering, -1 for one leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_reg <= '0;
    end else if (en) begin
      pop_reg <= pop_reg + CW'(din) - CW'(tag_reg[LAT-1]);
    end
  end

  assign tail    = tag_reg[LAT-1];
  assign any_set = (pop_reg != '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Input frame controller for the 128-point radix-2 SDF FFT pipeline.
// Accepts the sample stream, produces the free-running stage-1 counter and
// the pipeline advance enable, tags real samples so the output slots can be
// flagged valid, and zero-fills the pipeline to drain it after a frame.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   input sample present
//   in_sop    in   first sample of a frame (qualified by in_valid)
//   in_ready  out  sample accepted when in_valid & in_ready
//   stage_en  out  pipeline advance enable for all stages (combinational)
//   cnt_1     out  stage-1 sample counter (registered)
//   out_valid out  pipeline output slot holds a real sample this cycle
//   out_sop   out  first output of a frame
//   out_idx   out  output index within frame (registered, wraps)
//   busy      out  controller not idle
//   err_sop   out  one-cycle protocol-error pulse (registered)
// ---------------------------------------------------------------------------
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N   = FFT_N,
  parameter int LAT = FFT_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sop,
  output logic         in_ready,
  output logic         stage_en,
  output logic [N-1:0] cnt_1,
  output logic         out_valid,
  output logic         out_sop,
  output logic [N-1:0] out_idx,
  output logic         busy,
  output logic         err_sop
);

  ctrl_state_t  state_reg, state_next;
  logic [N-1:0] cnt_reg, cnt_next;
  logic [N-1:0] idx_reg;
  logic         err_reg, err_next;
  logic         sample_real;
  logic         tag_tail, tag_any;
  logic         cnt_zero, cnt_last, sop_in;

  assign cnt_zero = (cnt_reg == '0);
  assign cnt_last = (cnt_reg == '1);
  assign sop_in   = in_valid & in_sop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    in_ready    = 1'b1;
    stage_en    = 1'b0;
    sample_real = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Only a frame start moves the pipeline; stray data is dropped.
        stage_en    = sop_in;
        sample_real = sop_in;
        err_next    = in_valid & ~in_sop;
        if (sop_in) state_next = RUN;
      end
      RUN: begin
        // A missing sample stalls every stage together.
        stage_en    = in_valid;
        sample_real = in_valid;
        err_next    = sop_in & ~cnt_zero;
        if (in_valid && cnt_last) state_next = DRAIN;
      end
      DRAIN: begin
        // Bubbles keep flowing so butterfly timing stays aligned; a new
        // frame can only start on a frame boundary (cnt_1 == 0).
        stage_en = 1'b1;
        in_ready = cnt_zero;
        if (cnt_zero) begin
          sample_real = sop_in;
          err_next    = in_valid & ~in_sop;
          if (sop_in) begin
            state_next = RUN;
          end else if (!tag_any) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The counter stays at zero when falling back to IDLE so the next frame
  // starts from a clean boundary.
  always_comb begin
    cnt_next = cnt_reg;
    if (stage_en && (state_next != IDLE)) cnt_next = cnt_reg + N'(1);
  end

  fft_tag_delay #(
    .LAT(LAT)
  ) u_tag (
    .clk    (clk),
    .rst    (rst),
    .en     (stage_en),
    .din    (sample_real),
    .tail   (tag_tail),
    .any_set(tag_any)
  );

  assign out_valid = stage_en & tag_tail;
  assign out_sop   = out_valid & (idx_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (out_valid) begin
      idx_reg <= idx_reg + N'(1);
    end
  end

  assign cnt_1   = cnt_reg;
  assign out_idx = idx_reg;
  assign busy    = (state_reg != IDLE);
  assign err_sop = err_reg;

endmodule
